// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: register offsets, FSM states and
// STATUS/CTRL bit positions.
package uart_pkg;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAMING   = 3;
    localparam int STAT_PARITY    = 4;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_RX_EN     = 0;
    localparam int CTRL_DATA_IRQ  = 1;
    localparam int CTRL_ERR_IRQ   = 2;
    localparam int CTRL_THR_LSB   = 4;
    localparam int CTRL_PAR_EN    = 8;
    localparam int CTRL_PAR_ODD   = 9;

    // A programmed threshold of 0 behaves like 1 so the interrupt still means "data waiting".
    function automatic logic [3:0] eff_threshold(input logic [3:0] thr);
        return (thr == 4'd0) ? 4'd1 : thr;
    endfunction

endpackage

// File: rtl/uart_rx_dev_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop and a push in the same cycle are
// both honoured, so a push into a full FIFO succeeds when a pop accompanies it.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_dev.sv
// Memory-mapped 8N1 UART receiver with receive FIFO and level interrupt.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_dev #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DIV_RESET   = 16'd867,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        CS,
    input  logic        dbus_we,
    input  logic [3:0]  dbus_addr4,
    input  logic [31:0] dbus_in,
    output logic [31:0] dbus_out,
    input  logic        rx_in,
    output logic        irq_out
);
    import uart_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] r_div_lat;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        w_tick;
    logic        w_start;
    logic        w_reload;
    logic        w_shift;
    logic        w_push_req;
    logic        w_set_fe;

    logic        r_rx_en;
    logic        r_data_irq_en;
    logic        r_err_irq_en;
    logic [3:0]  r_thr;
    logic [15:0] r_div;
    logic        r_ovr;
    logic        r_fe;
    logic        r_irq;
    logic        w_pe_flag;
    logic        w_par_bad;
    logic        w_par_en;
    logic        w_par_odd;

    logic [1:0]  w_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_pop_req;
    logic        w_pop_eff;
    logic        w_set_ovr;
    logic [2:0]  w_clr;
    logic [31:0] w_status;
    logic [31:0] w_ctrl;
    logic        w_err_any;
    logic        w_unused;

    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
        end
    end
    assign w_rx_s = r_sync[SYNC_STAGES-1];

    assign w_sel     = dbus_addr4[3:2];
    assign w_wr      = CS && dbus_we;
    assign w_rd      = CS && !dbus_we;
    assign w_pop_req = w_rd && (w_sel == REG_RXDATA);
    assign w_pop_eff = w_pop_req && !w_empty;
    assign w_clr     = (w_wr && (w_sel == REG_STATUS)) ? dbus_in[4:2] : 3'b000;
    assign w_unused  = ^dbus_in[31:16];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_en       <= 1'b0;
            r_data_irq_en <= 1'b0;
            r_err_irq_en  <= 1'b0;
            r_thr         <= 4'd0;
            r_div         <= DIV_RESET;
        end else begin
            if (w_wr && (w_sel == REG_CTRL)) begin
                r_rx_en       <= dbus_in[CTRL_RX_EN];
                r_data_irq_en <= dbus_in[CTRL_DATA_IRQ];
                r_err_irq_en  <= dbus_in[CTRL_ERR_IRQ];
                r_thr         <= dbus_in[CTRL_THR_LSB +: 4];
            end
            if (w_wr && (w_sel == REG_DIV)) begin
                r_div <= dbus_in[15:0];
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_en;
    logic r_par_odd;
    logic r_par_bad;
    logic r_pe;
    logic w_set_pe;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
        end else if (w_wr && (w_sel == REG_CTRL)) begin
            r_par_en  <= dbus_in[CTRL_PAR_EN];
            r_par_odd <= dbus_in[CTRL_PAR_ODD];
        end
    end

    // Mismatch is remembered so the STOP state can still discard the byte.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad <= 1'b0;
            r_pe      <= 1'b0;
        end else begin
            if (w_start) begin
                r_par_bad <= 1'b0;
            end else if (w_set_pe) begin
                r_par_bad <= 1'b1;
            end
            r_pe <= (r_pe & ~w_clr[2]) | w_set_pe;
        end
    end

    assign w_par_en  = r_par_en;
    assign w_par_odd = r_par_odd;
    assign w_par_bad = r_par_bad;
    assign w_pe_flag = r_pe;
`else
    assign w_par_en  = 1'b0;
    assign w_par_odd = 1'b0;
    assign w_par_bad = 1'b0;
    assign w_pe_flag = 1'b0;
`endif

    assign w_tick = (r_cnt == 16'd0);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_reload    = 1'b0;
        w_shift     = 1'b0;
        w_push_req  = 1'b0;
        w_set_fe    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_set_pe    = 1'b0;
`endif
        if (!r_rx_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_start     = 1'b1;
                        w_state_nxt = START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_reload    = 1'b1;
                            w_state_nxt = DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        w_shift  = 1'b1;
                        w_reload = 1'b1;
                        if (r_bit == 3'd7) begin
                            w_state_nxt = w_par_en ? PARITY : STOP;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        w_reload    = 1'b1;
                        w_set_pe    = (w_rx_s != (w_par_odd ? ~^r_shift : ^r_shift));
                        w_state_nxt = STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        w_state_nxt = IDLE;
                        if (!w_rx_s) begin
                            w_set_fe = 1'b1;
                        end else if (!w_par_bad) begin
                            w_push_req = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Divisor is captured at the start edge so mid-frame DIV writes wait for the next frame.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
            r_bit <= 3'd0;
        end else begin
            if (w_start) begin
                r_cnt <= r_div >> 1;
                r_bit <= 3'd0;
            end else if (w_reload) begin
                r_cnt <= r_div_lat;
            end else if (!w_tick) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (w_shift) begin
                r_bit <= r_bit + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_start) begin
            r_div_lat <= r_div;
        end
        if (w_shift) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .i_push  (w_push_req),
        .i_data  (r_shift),
        .i_pop   (w_pop_req),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A set arriving on the same edge as a W1C clear takes priority.
    assign w_set_ovr = w_push_req && w_full && !w_pop_eff;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            r_ovr <= (r_ovr & ~w_clr[0]) | w_set_ovr;
            r_fe  <= (r_fe  & ~w_clr[1]) | w_set_fe;
        end
    end

    assign w_err_any = r_ovr | r_fe | w_pe_flag;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_data_irq_en && (32'(w_count) >= 32'(eff_threshold(r_thr))))
                  || (r_err_irq_en && w_err_any);
        end
    end
    assign irq_out = r_irq;

    always_comb begin
        w_status                          = '0;
        w_status[STAT_NOT_EMPTY]          = !w_empty;
        w_status[STAT_FULL]               = w_full;
        w_status[STAT_OVERRUN]            = r_ovr;
        w_status[STAT_FRAMING]            = r_fe;
        w_status[STAT_PARITY]             = w_pe_flag;
        w_status[STAT_COUNT_LSB +: 5]     = 5'(w_count);

        w_ctrl                            = '0;
        w_ctrl[CTRL_RX_EN]                = r_rx_en;
        w_ctrl[CTRL_DATA_IRQ]             = r_data_irq_en;
        w_ctrl[CTRL_ERR_IRQ]              = r_err_irq_en;
        w_ctrl[CTRL_THR_LSB +: 4]         = r_thr;
        w_ctrl[CTRL_PAR_EN]               = w_par_en;
        w_ctrl[CTRL_PAR_ODD]              = w_par_odd;

        dbus_out = 32'd0;
        if (CS) begin
            case (w_sel)
                REG_RXDATA: dbus_out = {24'd0, (w_empty ? 8'd0 : w_head)};
                REG_STATUS: dbus_out = w_status;
                REG_CTRL:   dbus_out = w_ctrl;
                default:    dbus_out = {16'd0, r_div};
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_dev.sv
// Directed self-checking bench for uart_rx_dev; parity cases are selected with UART_RX_PARITY_EN.
module tb_uart_rx_dev;

    localparam int BIT_CLKS = 10;

    logic        clk_in     = 1'b0;
    logic        rst_n      = 1'b0;
    logic        CS         = 1'b0;
    logic        dbus_we    = 1'b0;
    logic [3:0]  dbus_addr4 = 4'd0;
    logic [31:0] dbus_in    = 32'd0;
    logic [31:0] dbus_out;
    logic        rx_in      = 1'b1;
    logic        irq_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    uart_rx_dev dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .CS         (CS),
        .dbus_we    (dbus_we),
        .dbus_addr4 (dbus_addr4),
        .dbus_in    (dbus_in),
        .dbus_out   (dbus_out),
        .rx_in      (rx_in),
        .irq_out    (irq_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk_in);
        CS = 1'b1; dbus_we = 1'b1; dbus_addr4 = addr; dbus_in = data;
        @(negedge clk_in);
        CS = 1'b0; dbus_we = 1'b0; dbus_in = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk_in);
        CS = 1'b1; dbus_we = 1'b0; dbus_addr4 = addr;
        #1 data = dbus_out;
        @(negedge clk_in);
        CS = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(addr, v);
        check(tag, v, exp);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par, input logic stop);
        @(negedge clk_in);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (with_par) send_bit(par);
        send_bit(stop);
        rx_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk_in);
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Reset state
        check("rst_irq", {31'd0, irq_out}, 32'd0);
        check("rst_dbus_idle", dbus_out, 32'd0);
        read_check("rst_status", 4'h4, 32'h0);
        read_check("rst_ctrl", 4'h8, 32'h0);
        read_check("rst_div", 4'hC, 32'd867);
        read_check("rst_rxdata_empty", 4'h0, 32'h0);

        // Single byte with data+err interrupts
        bus_write(4'hC, 32'd9);
        bus_write(4'h8, 32'h7);
        read_check("div_rb", 4'hC, 32'd9);
        read_check("ctrl_rb", 4'h8, 32'h7);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        read_check("a5_status", 4'h4, 32'h101);
        check("a5_irq", {31'd0, irq_out}, 32'd1);
        read_check("a5_rxdata", 4'h0, 32'hA5);
        read_check("a5_status_after", 4'h4, 32'h0);
        @(negedge clk_in);
        check("a5_irq_after", {31'd0, irq_out}, 32'd0);

        // Overrun: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        read_check("ovr_status", 4'h4, 32'h1007);
        for (int i = 0; i < 16; i++) read_check($sformatf("ovr_rd%0d", i), 4'h0, 32'(i));
        read_check("ovr_sticky", 4'h4, 32'h004);
        check("ovr_irq", {31'd0, irq_out}, 32'd1);
        bus_write(4'h4, 32'h4);
        read_check("ovr_cleared", 4'h4, 32'h0);
        @(negedge clk_in);
        check("ovr_irq_cleared", {31'd0, irq_out}, 32'd0);

        // Framing error keeps earlier data, then W1C clears only the flag
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        read_check("fe_status", 4'h4, 32'h109);
        bus_write(4'h4, 32'h8);
        read_check("fe_cleared", 4'h4, 32'h101);
        read_check("fe_rxdata", 4'h0, 32'h3C);

        // Glitch shorter than half a bit is a false start
        @(negedge clk_in);
        rx_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rx_in = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk_in);
        read_check("glitch_status", 4'h4, 32'h0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        read_check("glitch_next", 4'h0, 32'h81);

        // Threshold 4, data interrupt only
        bus_write(4'h8, 32'h43);
        for (int i = 0; i < 3; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        check("thr_irq3", {31'd0, irq_out}, 32'd0);
        send_frame(8'h13, 1'b0, 1'b0, 1'b1);
        check("thr_irq4", {31'd0, irq_out}, 32'd1);
        read_check("thr_rd0", 4'h0, 32'h10);
        @(negedge clk_in);
        check("thr_irq_drop", {31'd0, irq_out}, 32'd0);
        for (int i = 1; i < 4; i++) read_check($sformatf("thr_rd%0d", i), 4'h0, 32'h10 + 32'(i));

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x03 has two ones, so a parity bit of 1 is wrong
        bus_write(4'h8, 32'h107);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        read_check("par_err_status", 4'h4, 32'h010);
        bus_write(4'h4, 32'h10);
        read_check("par_cleared", 4'h4, 32'h0);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        read_check("par_ok_status", 4'h4, 32'h101);
        read_check("par_ok_rxdata", 4'h0, 32'h03);
        bus_write(4'h8, 32'h307);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        read_check("par_odd_rxdata", 4'h0, 32'h03);
`else
        bus_write(4'h8, 32'h307);
        read_check("nopar_ctrl", 4'h8, 32'h007);
        bus_write(4'h4, 32'h10);
        read_check("nopar_status", 4'h4, 32'h0);
`endif

        // Reset in the middle of a frame
        bus_write(4'h8, 32'h7);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        check("prerst_irq", {31'd0, irq_out}, 32'd1);
        @(negedge clk_in);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_irq", {31'd0, irq_out}, 32'd0);
        check("midrst_dbus", dbus_out, 32'd0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        read_check("postrst_status", 4'h4, 32'h0);
        read_check("postrst_ctrl", 4'h8, 32'h0);
        read_check("postrst_div", 4'hC, 32'd867);
        bus_write(4'hC, 32'd9);
        bus_write(4'h8, 32'h1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        read_check("postrst_rx_status", 4'h4, 32'h101);
        read_check("postrst_rxdata", 4'h0, 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
